rca_seq_ctrl: RTL and testbench

Multi-precision add/subtract sequencer that time-shares one external 10-bit ripple-carry adder slice across WORDS consecutive 10-bit limbs. It accepts wide operands on a valid/ready handshake and feeds one limb per cycle to the slice, least-significant limb first. Between limbs it keeps the carry in a register, collects the sum limbs and returns the wide result on a second valid/ready handshake. It sits between operand-issuing logic and the shared adder, so a small adder can serve wide arithmetic.

---
 rtl/rca_seq_ctrl.sv | 128 ++++++++++++
 tb/tb_rca_seq_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rca_seq_ctrl.sv
// Multi-precision add/subtract sequencer. It streams WORDS limbs, least-significant
// first, through one shared external 10-bit ripple-carry slice and returns the wide result.
module rca_seq_ctrl #(
    parameter int WORDS = 4,
    parameter int SLICE = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [SLICE*WORDS-1:0] op_a,
    input  logic [SLICE*WORDS-1:0] op_b,
    input  logic                   op_sub,
    input  logic                   op_cin,
    output logic [SLICE-1:0]       add_a,
    output logic [SLICE-1:0]       add_b,
    output logic                   add_cin,
    input  logic [SLICE-1:0]       add_sum,
    input  logic                   add_cout,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [SLICE*WORDS-1:0] sum,
    output logic                   cout,
    output logic                   ovf,
    output logic                   busy
);

    localparam int W     = SLICE * WORDS;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        carry_d   = carry_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        add_a     = '0;
        add_b     = '0;
        add_cin   = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    // Subtract is A + ~B + 1: B is stored inverted and the carry seeds the +1.
                    a_d     = op_a;
                    b_d     = op_sub ? ~op_b : op_b;
                    carry_d = op_sub | op_cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy    = 1'b1;
                add_a   = a_q[SLICE*int'(idx_q) +: SLICE];
                add_b   = b_q[SLICE*int'(idx_q) +: SLICE];
                add_cin = carry_q;
                sum_d[SLICE*int'(idx_q) +: SLICE] = add_sum;
                carry_d = add_cout;
                if (idx_q == LAST_IDX) begin
                    // Overflow is judged on the operands the slice actually saw (inverted B on subtract).
                    cout_d  = add_cout;
                    ovf_d   = (a_q[W-1] == b_q[W-1]) & (add_sum[SLICE-1] != a_q[W-1]);
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Bench for rca_seq_ctrl: directed and random operations checked against a
// wide-integer reference model; the shared adder slice is modelled combinationally.
module tb_rca_seq_ctrl;

    localparam int WORDS = 4;
    localparam int SLICE = 10;
    localparam int W     = SLICE * WORDS;

    logic               clk;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic [W-1:0]       op_a;
    logic [W-1:0]       op_b;
    logic               op_sub;
    logic               op_cin;
    logic [SLICE-1:0]   add_a;
    logic [SLICE-1:0]   add_b;
    logic               add_cin;
    logic [SLICE-1:0]   add_sum;
    logic               add_cout;
    logic               out_valid;
    logic               out_ready;
    logic [W-1:0]       sum;
    logic               cout;
    logic               ovf;
    logic               busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] exp_sum;
    logic         exp_cout;
    logic         exp_ovf;
    logic [W-1:0] cur_a;
    logic [W-1:0] cur_b;
    logic         cur_sub;
    logic         cur_cin;

    rca_seq_ctrl #(.WORDS(WORDS), .SLICE(SLICE)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_sub    (op_sub),
        .op_cin    (op_cin),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    // External ripple-carry slice shared by the sequencer
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{SLICE{1'b0}}, add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference model: plain wide-integer arithmetic, signed overflow by range test
    function automatic void set_expect(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic sub, input logic cin);
        logic signed [W-1:0] sa;
        logic signed [W-1:0] sb;
        longint la, lb, r, max_s, min_s;
        logic [W:0] u;
        sa = a;
        sb = b;
        la = sa;
        lb = sb;
        max_s = (longint'(1) <<< (W - 1)) - 1;
        min_s = -(longint'(1) <<< (W - 1));
        if (sub) begin
            r        = la - lb;
            u        = {1'b0, a} - {1'b0, b};
            exp_cout = (a >= b);
        end else begin
            r        = la + lb + longint'(cin);
            u        = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
            exp_cout = u[W];
        end
        exp_sum = u[W-1:0];
        exp_ovf = (r > max_s) || (r < min_s);
        cur_a   = a;
        cur_b   = b;
        cur_sub = sub;
        cur_cin = cin;
    endfunction

    function automatic logic [SLICE-1:0] limb(input logic [W-1:0] v, input int k);
        logic [W-1:0] t;
        t = v >> (SLICE * k);
        return t[SLICE-1:0];
    endfunction

    // Carry entering limb k: carry out of the low k limbs (no-borrow for subtract)
    function automatic logic carry_into(input int k);
        logic [63:0] m, la, lb;
        m  = (64'd1 << (SLICE * k)) - 64'd1;
        la = 64'(cur_a) & m;
        lb = 64'(cur_b) & m;
        if (cur_sub) return (la >= lb);
        return ((la + lb + 64'(cur_cin)) >> (SLICE * k)) != 64'd0;
    endfunction

    function automatic logic [W-1:0] rnd_operand();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return {1'b0, {(W-1){1'b1}}};
            3:       return {1'b1, {(W-1){1'b0}}};
            default: return r[W-1:0];
        endcase
    endfunction

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic sub, input logic cin);
        op_a     = a;
        op_b     = b;
        op_sub   = sub;
        op_cin   = cin;
        in_valid = 1'b1;
        for (int i = 0; i < 20 && !in_ready; i++) tick();
        check("accept_ready", in_ready, 1);
        set_expect(a, b, sub, cin);
        tick();
        in_valid = 1'b0;
        op_a     = ~a;
        op_b     = ~b;
        op_sub   = ~sub;
        op_cin   = ~cin;
    endtask

    task automatic run_checks();
        logic [W-1:0] bx;
        bx = cur_sub ? ~cur_b : cur_b;
        for (int k = 0; k < WORDS; k++) begin
            check("run_out_valid", out_valid, 0);
            check("run_busy", busy, 1);
            check("run_in_ready", in_ready, 0);
            check("limb_a", add_a, limb(cur_a, k));
            check("limb_b", add_b, limb(bx, k));
            check("limb_cin", add_cin, carry_into(k));
            tick();
        end
        check("latency_out_valid", out_valid, 1);
        check("done_in_ready", in_ready, 0);
    endtask

    task automatic finish_op(input int hold);
        if (hold > 0) out_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            check("bp_out_valid", out_valid, 1);
            check("bp_sum", sum, exp_sum);
            check("bp_in_ready", in_ready, 0);
            tick();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 20 && !out_valid; i++) tick();
        check("res_valid", out_valid, 1);
        check("res_sum", sum, exp_sum);
        check("res_cout", cout, exp_cout);
        check("res_ovf", ovf, exp_ovf);
        tick();
        out_ready = 1'b0;
        check("post_out_valid", out_valid, 0);
        check("post_in_ready", in_ready, 1);
        check("idle_hold_sum", sum, exp_sum);
        check("idle_hold_cout", cout, exp_cout);
    endtask

    task automatic full_op(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic sub, input logic cin, input int hold);
        start_op(a, b, sub, cin);
        run_checks();
        finish_op(hold);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_sum"}, sum, 0);
        check({tag, "_cout"}, cout, 0);
        check({tag, "_ovf"}, ovf, 0);
        check({tag, "_add_a"}, add_a, 0);
        check({tag, "_add_b"}, add_b, 0);
        check({tag, "_add_cin"}, add_cin, 0);
    endtask

    initial begin
        logic [W-1:0] a2, b2;
        reset     = 1'b1;
        in_valid  = 1'b0;
        op_a      = '0;
        op_b      = '0;
        op_sub    = 1'b0;
        op_cin    = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check_reset_state("reset");

        // Carry out of limb 0 into limb 1
        full_op(40'h00000003FF, 40'h0000000001, 1'b0, 1'b0, 0);
        // Carry ripples through every limb
        full_op(40'hFFFFFFFFFF, 40'h0000000000, 1'b0, 1'b1, 0);
        // Subtract with and without borrow; op_cin must be ignored
        full_op(40'h0000000005, 40'h0000000007, 1'b1, 1'b1, 0);
        full_op(40'h0000000007, 40'h0000000005, 1'b1, 1'b0, 0);
        // Signed overflow on add and subtract
        full_op(40'h7FFFFFFFFF, 40'h0000000001, 1'b0, 1'b0, 0);
        full_op(40'h8000000000, 40'h0000000001, 1'b1, 1'b0, 0);

        // Backpressure with a second request held pending
        a2 = 40'h123456789A;
        b2 = 40'h0FEDCBA987;
        start_op(40'h00000FFC00, 40'h0000000400, 1'b0, 1'b0);
        run_checks();
        out_ready = 1'b0;
        op_a      = a2;
        op_b      = b2;
        op_sub    = 1'b1;
        op_cin    = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("hold_out_valid", out_valid, 1);
            check("hold_sum", sum, exp_sum);
            check("hold_in_ready", in_ready, 0);
            tick();
        end
        out_ready = 1'b1;
        check("hold_res_sum", sum, exp_sum);
        check("hold_res_cout", cout, exp_cout);
        tick();
        out_ready = 1'b0;
        check("hs_out_valid", out_valid, 0);
        check("hs_not_started", busy, 0);
        check("hs_in_ready", in_ready, 1);
        full_op(a2, b2, 1'b1, 1'b0, 0);

        // out_ready raised early has no effect until the result is valid
        out_ready = 1'b1;
        full_op(40'h00FFFFFFFF, 40'h0000000001, 1'b0, 1'b0, 0);

        // Reset in the middle of RUN aborts the operation
        start_op(40'h3333333333, 40'h1111111111, 1'b0, 1'b1);
        tick();
        tick();
        check("mid_limb2_a", add_a, limb(cur_a, 2));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_state("abort");
        tick();
        check("abort_no_result", out_valid, 0);
        full_op(40'h3333333333, 40'h1111111111, 1'b0, 1'b1, 1);

        // Reset coinciding with an accepting handshake wins
        op_a     = 40'h0000000042;
        op_b     = 40'h0000000001;
        op_sub   = 1'b0;
        op_cin   = 1'b0;
        in_valid = 1'b1;
        reset    = 1'b1;
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        check("rst_hs_busy", busy, 0);
        tick();
        check("rst_hs_busy_later", busy, 0);
        check("rst_hs_add_a", add_a, 0);

        // Randomized operations with random backpressure
        for (int n = 0; n < 40; n++) begin
            out_ready = ($urandom_range(0, 3) == 0);
            full_op(rnd_operand(), rnd_operand(), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), $urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
